// File: rtl/dct_avm_master.sv
// Streams 8-sample blocks through an Avalon-MM DCT slave: load samples, write them, read coefficients back, stream them out.
// Optional block counter output blk_cnt is enabled with `define DCT_MASTER_BLKCNT_EN.
module dct_avm_master #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         SAMPLES   = 8
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic [15:0] asi_in_data,
    input  logic        asi_in_valid,
    output logic        asi_in_ready,
    output logic [15:0] aso_out_data,
    output logic        aso_out_valid,
    input  logic        aso_out_ready,
    output logic        aso_out_sop,
    output logic        aso_out_eop,
`ifdef DCT_MASTER_BLKCNT_EN
    output logic [15:0] blk_cnt,
`endif
    output logic [7:0]  avm_m0_address,
    output logic        avm_m0_write,
    output logic        avm_m0_read,
    output logic [31:0] avm_m0_writedata,
    input  logic [31:0] avm_m0_readdata
);

    typedef enum logic [1:0] {LOAD, WR, RD, OUT} state_t;

    localparam logic [2:0] LAST = 3'(SAMPLES - 1);

    state_t      state, state_next;
    logic [2:0]  idx, idx_next;
    logic        rd_tail, rd_tail_next;
    logic        rd_pend;
    logic [2:0]  rd_idx;
    logic        out_accept;
    logic [15:0] sample [SAMPLES];
    logic [15:0] coef   [SAMPLES];
    logic        unused_readdata_hi;

    assign unused_readdata_hi = ^avm_m0_readdata[31:16];
    assign out_accept         = (state == OUT) && aso_out_valid && aso_out_ready;

    assign asi_in_ready     = (state == LOAD);
    assign avm_m0_write     = (state == WR);
    // rd_tail is the extra RD cycle that only collects the last read's data
    assign avm_m0_read      = (state == RD) && !rd_tail;
    assign avm_m0_address   = (avm_m0_write || avm_m0_read) ? (BASE_ADDR + {5'b0, idx}) : 8'h00;
    assign avm_m0_writedata = avm_m0_write ? {16'h0000, sample[idx]} : 32'h0;

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        rd_tail_next = rd_tail;
        case (state)
            LOAD: begin
                if (asi_in_valid) begin
                    idx_next = idx + 3'd1;
                    if (idx == LAST) state_next = WR;
                end
            end
            WR: begin
                idx_next = idx + 3'd1;
                if (idx == LAST) state_next = RD;
            end
            RD: begin
                if (rd_tail) begin
                    state_next   = OUT;
                    rd_tail_next = 1'b0;
                    idx_next     = 3'd0;
                end else begin
                    idx_next = idx + 3'd1;
                    if (idx == LAST) rd_tail_next = 1'b1;
                end
            end
            OUT: begin
                if (out_accept) begin
                    idx_next = idx + 3'd1;
                    if (idx == LAST) state_next = LOAD;
                end
            end
            default: begin
                state_next   = LOAD;
                idx_next     = 3'd0;
                rd_tail_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            state   <= LOAD;
            idx     <= 3'd0;
            rd_tail <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            rd_tail <= rd_tail_next;
        end
    end

    // The output register is primed on the first OUT cycle, then reloaded on each accepted beat
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            for (int k = 0; k < SAMPLES; k++) begin
                sample[k] <= 16'h0;
                coef[k]   <= 16'h0;
            end
            rd_pend       <= 1'b0;
            rd_idx        <= 3'd0;
            aso_out_data  <= 16'h0;
            aso_out_valid <= 1'b0;
            aso_out_sop   <= 1'b0;
            aso_out_eop   <= 1'b0;
        end else begin
            if (state == LOAD && asi_in_valid) sample[idx] <= asi_in_data;
            rd_pend <= avm_m0_read;
            rd_idx  <= idx;
            if (rd_pend) coef[rd_idx] <= avm_m0_readdata[15:0];
            if (state == OUT) begin
                if (!aso_out_valid) begin
                    aso_out_data  <= coef[idx];
                    aso_out_valid <= 1'b1;
                    aso_out_sop   <= (idx == 3'd0);
                    aso_out_eop   <= (idx == LAST);
                end else if (aso_out_ready) begin
                    if (idx == LAST) begin
                        aso_out_data  <= 16'h0;
                        aso_out_valid <= 1'b0;
                        aso_out_sop   <= 1'b0;
                        aso_out_eop   <= 1'b0;
                    end else begin
                        aso_out_data <= coef[idx + 3'd1];
                        aso_out_sop  <= 1'b0;
                        aso_out_eop  <= ((idx + 3'd1) == LAST);
                    end
                end
            end
        end
    end

`ifdef DCT_MASTER_BLKCNT_EN
    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) blk_cnt <= 16'h0;
        else if (out_accept && aso_out_eop) blk_cnt <= blk_cnt + 16'h1;
    end
`endif

endmodule
